cvxif_copro_responder: RTL
==========================

// Module: cvxif_copro_responder
// PURPOSE
//  Coprocessor-side responder for the CV-X-IF offload interface: accepts issue, register and
//  commit transactions from the core's issue stage, executes a small custom-0 instruction set
//  and returns results. Sits outside the core, facing the core's x_issue/x_register/x_commit/x_result ports.
// PARAMETERS
//  CVA6Cfg      cva6_cfg_empty  core config; uses XLEN and TRANS_ID_BITS (ID width)
//  NrEntries    4               in-order pending-instruction queue depth (power of 2, >=2)
//  ExecLatency  2               cycles from execute start to result_valid_o (>=1)
// PORTS
//  clk_i              in   1        clock
//  rst_ni             in   1        async reset, active low
//  issue_valid_i      in   1        issue request valid
//  issue_ready_o      out  1        queue can take an issue request
//  issue_instr_i      in   32       offloaded instruction word
//  issue_id_i         in   TRANS_ID transaction id
//  issue_accept_o     out  1        instruction recognised (comb, valid during issue handshake)
//  issue_writeback_o  out  1        instruction will write rd
//  issue_regread_o    out  2        rs1/rs2 operand needed
//  register_valid_i   in   1        operand transfer valid
//  register_ready_o   out  1        operand transfer can be taken
//  register_id_i      in   TRANS_ID id of operand transfer
//  register_rs_i      in   2xXLEN   rs1, rs2 values
//  commit_valid_i     in   1        commit/kill message valid (always taken)
//  commit_id_i        in   TRANS_ID id being committed
//  commit_kill_i      in   1        1 = discard instruction
//  result_valid_o     out  1        result valid
//  result_ready_i     in   1        core takes result
//  result_id_o        out  TRANS_ID id of result
//  result_data_o      out  XLEN     result value
//  result_rd_o        out  5        destination register
//  result_we_o        out  1        write enable
// BEHAVIOUR
//  - Reset: queue empty, FSM IDLE, accumulator 0; issue_ready_o=1, register_ready_o=0, result_* = 0.
//  - Decode (opcode 7'b0001011): funct3 000 CUS_ADD rd=rs1+rs2; 010 CUS_SUB rd=rs1-rs2;
//    001 CUS_NOP (accept, writeback=0, regread=00). Other opcode/funct3: accept=0, writeback=0, regread=00.
//  - Issue: handshake on valid&ready; issue_ready_o = !full (registered count, no same-cycle pop bypass).
//    Accepted instr allocated at tail {id,rd,op,has_ops=!regread,committed=0,killed=0}; rejected: no allocation.
//  - Register: ready when an accepted entry lacks operands, incl. one allocated this cycle. Operands go to the
//    oldest entry lacking them; id mismatch is a protocol error (assertion), data still written.
//  - Commit: applied to the entry with matching id, including a same-cycle allocation; unmatched id ignored.
//    kill=1 sets killed; commit/kill on an already-committed entry is ignored.
//  - FSM on head entry: IDLE -> pop in 1 cycle if killed, or if committed & NOP;
//    IDLE -> EXEC if committed & has_ops & writeback; EXEC counts ExecLatency-1..0 -> RESULT;
//    RESULT holds result_* stable with valid=1 until result_ready_i, then pops -> IDLE.
//    Back-to-back results: at most one result every ExecLatency+1 cycles.
//  - Arithmetic: XLEN-wide, modulo 2^XLEN, no exceptions. Pointers wrap modulo NrEntries.
//  - Simultaneous issue+pop: count = count+1-1. Full: issue_ready_o=0 until a pop registers.
//  - Async reset mid-operation: all entries dropped, in-flight result lost, outputs to reset values.
// CONFIGURATION
//  CVXIF_COPRO_MAC_EN defined: funct3 100 CUS_MAC accepted (writeback=1, regread=11);
//    acc <= acc + rs1*rs2 (low XLEN bits) on entering RESULT, result_data_o = new acc.
//    funct3 101 CUS_CLRACC accepted (writeback=1, regread=00): acc<=0, result 0.
//  Undefined: funct3 100/101 rejected; no multiplier or accumulator instantiated.
// STRUCTURE
//  cvxif_copro_pkg: OPCODE_CUSTOM0, funct3 constants, copro_op_e, copro_entry_t, fsm state_e.
//  Sub-module cvxif_copro_decoder (comb: instr -> accept/writeback/regread/op). Queue and FSM inline.
// TESTING
//  - ADD id=1 rs1=5 rs2=7 rd=x3, reg same cycle, commit id=1 -> result id=1 data=12 rd=3 we=1 after ExecLatency+1 cycles.
//  - Issue opcode 0x33 -> accept=0, no entry; register_ready_o stays 0; no result ever.
//  - Issue SUB ids 0..3 without commit -> issue_ready_o=0 on 5th; commit id=0, result taken -> ready=1 again.
//  - Issue ADD id=2, commit kill -> popped within 1 cycle, no result_valid_o; next ADD id=3 (1+1) returns 2.
//  - Hold result_ready_i=0 for 10 cycles -> result_valid_o/data stable; SUB 0-1 returns all-ones (XLEN).
//  - MAC_EN: MAC 3*4 then MAC 2*5 -> results 12 then 22; CLRACC -> 0; without macro MAC -> accept=0.

Source files
------------

// File: rtl/cvxif_copro_pkg.sv
// -----------------------------------------------------------------------------
// cvxif_copro_pkg
// Shared types and constants for the CV-X-IF coprocessor responder:
//   cva6_cfg_t / cva6_cfg_empty : minimal core configuration (XLEN, id width)
//   OPCODE_CUSTOM0, F3_*        : custom-0 instruction encodings
//   copro_op_e                  : decoded operation
//   copro_entry_t               : one pending-instruction queue slot
//   state_e                     : execute FSM states
// Optional feature macro: CVXIF_COPRO_MAC_EN (enables CUS_MAC / CUS_CLRACC).
// -----------------------------------------------------------------------------
package cvxif_copro_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 4};

    // Queue slots store ids at this fixed width; narrower ids are zero-extended.
    localparam int unsigned ID_MAX_W = 8;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_ADD         = 3'b000;
    localparam logic [2:0] F3_NOP         = 3'b001;
    localparam logic [2:0] F3_SUB         = 3'b010;
    localparam logic [2:0] F3_MAC         = 3'b100;
    localparam logic [2:0] F3_CLRACC      = 3'b101;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_MAC,
        OP_CLRACC
    } copro_op_e;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [4:0]          rd;
        copro_op_e           op;
        logic                writeback;
        logic                has_ops;
        logic                committed;
        logic                killed;
    } copro_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESULT
    } state_e;

endpackage

// File: rtl/cvxif_copro_if.sv
// -----------------------------------------------------------------------------
// cvxif_copro_if
// Bundles the issue / register / commit / result channels between the core
// (master modport) and the coprocessor responder (slave modport). Signal
// names carry the coprocessor's point of view (_i into the coprocessor).
//   issue_*    : instruction offer and decode answer
//   register_* : rs1/rs2 operand transfer
//   commit_*   : commit or kill of an issued instruction
//   result_*   : write-back result with valid/ready handshake
// -----------------------------------------------------------------------------
interface cvxif_copro_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ID_W = 4
);
    logic                      issue_valid_i;
    logic                      issue_ready_o;
    logic [31:0]               issue_instr_i;
    logic [ID_W-1:0]           issue_id_i;
    logic                      issue_accept_o;
    logic                      issue_writeback_o;
    logic [1:0]                issue_regread_o;

    logic                      register_valid_i;
    logic                      register_ready_o;
    logic [ID_W-1:0]           register_id_i;
    logic [1:0][XLEN-1:0]      register_rs_i;

    logic                      commit_valid_i;
    logic [ID_W-1:0]           commit_id_i;
    logic                      commit_kill_i;

    logic                      result_valid_o;
    logic                      result_ready_i;
    logic [ID_W-1:0]           result_id_o;
    logic [XLEN-1:0]           result_data_o;
    logic [4:0]                result_rd_o;
    logic                      result_we_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o, issue_regread_o,
        output register_valid_i, register_id_i, register_rs_i,
        input  register_ready_o,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        output result_ready_i
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o, issue_regread_o,
        input  register_valid_i, register_id_i, register_rs_i,
        output register_ready_o,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
        input  result_ready_i
    );
endinterface

// File: rtl/cvxif_copro_decoder.sv
// -----------------------------------------------------------------------------
// cvxif_copro_decoder
// Combinational decode of the custom-0 instruction set.
//   opcode_i, funct3_i : instruction fields
//   accept_o           : instruction recognised
//   writeback_o        : instruction writes rd
//   regread_o          : rs2/rs1 operands needed
//   op_o               : decoded operation
// Optional feature macro: CVXIF_COPRO_MAC_EN (accepts CUS_MAC / CUS_CLRACC).
// -----------------------------------------------------------------------------
module cvxif_copro_decoder
    import cvxif_copro_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output logic       accept_o,
    output logic       writeback_o,
    output logic [1:0] regread_o,
    output copro_op_e  op_o
);

    always_comb begin
        accept_o    = 1'b0;
        writeback_o = 1'b0;
        regread_o   = 2'b00;
        op_o        = OP_NOP;
        if (opcode_i == OPCODE_CUSTOM0) begin
            unique case (funct3_i)
                F3_ADD: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    regread_o   = 2'b11;
                    op_o        = OP_ADD;
                end
                F3_SUB: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    regread_o   = 2'b11;
                    op_o        = OP_SUB;
                end
                F3_NOP: begin
                    accept_o    = 1'b1;
                    op_o        = OP_NOP;
                end
`ifdef CVXIF_COPRO_MAC_EN
                F3_MAC: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    regread_o   = 2'b11;
                    op_o        = OP_MAC;
                end
                F3_CLRACC: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    op_o        = OP_CLRACC;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// -----------------------------------------------------------------------------
// cvxif_copro_responder
// Coprocessor-side CV-X-IF responder: in-order pending queue, operand capture,
// commit/kill tracking and a head-of-queue execute FSM producing results.
//   clk_i  : clock
//   rst_ni : asynchronous reset, active low
//   x_if   : cvxif_copro_if slave modport (issue/register/commit/result)
// Parameters: CVA6Cfg (XLEN, TRANS_ID_BITS), NrEntries (power of 2, >=2),
//             ExecLatency (>=1).
// Optional feature macro: CVXIF_COPRO_MAC_EN (multiply-accumulate unit).
// -----------------------------------------------------------------------------
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg     = cva6_cfg_empty,
    parameter int unsigned NrEntries   = 4,
    parameter int unsigned ExecLatency = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    cvxif_copro_if.slave x_if
);

    localparam int unsigned XLEN = CVA6Cfg.XLEN;
    localparam int unsigned IdW  = CVA6Cfg.TRANS_ID_BITS;
    localparam int unsigned PtrW = $clog2(NrEntries);
    localparam int unsigned CntW = (ExecLatency > 1) ? $clog2(ExecLatency) : 1;

    copro_entry_t    q     [NrEntries];
    logic [XLEN-1:0] rs1_q [NrEntries];
    logic [XLEN-1:0] rs2_q [NrEntries];
    logic [PtrW-1:0] head_q, tail_q;
    logic [PtrW:0]   count_q;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            dec_accept, dec_writeback;
    logic [1:0]      dec_regread;
    copro_op_e       dec_op;

    logic            full, alloc, pop, load_result;
    logic            reg_hit, reg_fire;
    logic [PtrW-1:0] reg_idx;
    logic [ID_MAX_W-1:0] reg_target_id;
    logic            com_found, com_hit, com_fire;
    logic [PtrW-1:0] com_idx;
    copro_entry_t    head_e, new_e;
    logic [XLEN-1:0] result_value;

    logic [IdW-1:0]  res_id_q;
    logic [XLEN-1:0] res_data_q;
    logic [4:0]      res_rd_q;
    logic            res_we_q;

    logic            unused_instr_bits;
    assign unused_instr_bits = ^x_if.issue_instr_i[31:15];

    function automatic logic [PtrW-1:0] slot_of(input logic [PtrW-1:0] base, input int offs);
        return base + PtrW'(offs);
    endfunction

    cvxif_copro_decoder u_decoder (
        .opcode_i    (x_if.issue_instr_i[6:0]),
        .funct3_i    (x_if.issue_instr_i[14:12]),
        .accept_o    (dec_accept),
        .writeback_o (dec_writeback),
        .regread_o   (dec_regread),
        .op_o        (dec_op)
    );

    // Full is taken from the registered count only; a pop in the same
    // cycle does not reopen the issue port until it has registered.
    assign full  = (count_q == (PtrW + 1)'(NrEntries));
    assign alloc = x_if.issue_valid_i && !full && dec_accept;

    always_comb begin
        new_e           = '0;
        new_e.id        = ID_MAX_W'(x_if.issue_id_i);
        new_e.rd        = x_if.issue_instr_i[11:7];
        new_e.op        = dec_op;
        new_e.writeback = dec_writeback;
        new_e.has_ops   = (dec_regread == 2'b00);
    end

    // Operands go to the oldest entry still waiting for them; an entry
    // being allocated this cycle is the youngest candidate.
    always_comb begin
        reg_hit       = 1'b0;
        reg_idx       = tail_q;
        reg_target_id = new_e.id;
        for (int i = 0; i < int'(NrEntries); i++) begin
            if (!reg_hit && (i < int'(count_q)) && !q[slot_of(head_q, i)].has_ops) begin
                reg_hit       = 1'b1;
                reg_idx       = slot_of(head_q, i);
                reg_target_id = q[slot_of(head_q, i)].id;
            end
        end
        if (!reg_hit && alloc && (dec_regread != 2'b00)) begin
            reg_hit = 1'b1;
            reg_idx = tail_q;
        end
    end

    assign reg_fire = x_if.register_valid_i && reg_hit;

    // Commit lookup by id; the first id match wins and is ignored if that
    // entry was already committed or killed.
    always_comb begin
        com_found = 1'b0;
        com_hit   = 1'b0;
        com_idx   = tail_q;
        for (int i = 0; i < int'(NrEntries); i++) begin
            if (!com_found && (i < int'(count_q)) &&
                (q[slot_of(head_q, i)].id == ID_MAX_W'(x_if.commit_id_i))) begin
                com_found = 1'b1;
                com_hit   = !q[slot_of(head_q, i)].committed;
                com_idx   = slot_of(head_q, i);
            end
        end
        if (!com_found && alloc && (x_if.issue_id_i == x_if.commit_id_i)) begin
            com_hit = 1'b1;
            com_idx = tail_q;
        end
    end

    assign com_fire = x_if.commit_valid_i && com_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(NrEntries); i++) begin
                q[i]     <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
            end
        end else begin
            if (alloc) begin
                q[tail_q] <= new_e;
                tail_q    <= tail_q + PtrW'(1);
            end
            if (reg_fire) begin
                q[reg_idx].has_ops <= 1'b1;
                rs1_q[reg_idx]     <= x_if.register_rs_i[0];
                rs2_q[reg_idx]     <= x_if.register_rs_i[1];
            end
            if (com_fire) begin
                q[com_idx].committed <= 1'b1;
                q[com_idx].killed    <= x_if.commit_kill_i;
            end
            if (pop) begin
                head_q <= head_q + PtrW'(1);
            end
            unique case ({alloc, pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: ;
            endcase
        end
    end

    assign head_e = q[head_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Killed entries and committed non-writeback entries leave straight
    // from IDLE; everything else runs the fixed-latency execute path.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        load_result = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    if (head_e.killed) begin
                        pop = 1'b1;
                    end else if (head_e.committed && !head_e.writeback) begin
                        pop = 1'b1;
                    end else if (head_e.committed && head_e.has_ops) begin
                        state_d = S_EXEC;
                        cnt_d   = CntW'(ExecLatency - 1);
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d     = S_RESULT;
                    load_result = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            S_RESULT: begin
                if (x_if.result_ready_i) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CVXIF_COPRO_MAC_EN
    logic [XLEN-1:0] acc_q;

    always_comb begin
        result_value = '0;
        unique case (head_e.op)
            OP_ADD:  result_value = rs1_q[head_q] + rs2_q[head_q];
            OP_SUB:  result_value = rs1_q[head_q] - rs2_q[head_q];
            OP_MAC:  result_value = acc_q + rs1_q[head_q] * rs2_q[head_q];
            default: result_value = '0;
        endcase
    end

    // The accumulator takes the same value that is reported as the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (load_result && ((head_e.op == OP_MAC) || (head_e.op == OP_CLRACC))) begin
            acc_q <= result_value;
        end
    end
`else
    always_comb begin
        result_value = '0;
        unique case (head_e.op)
            OP_ADD:  result_value = rs1_q[head_q] + rs2_q[head_q];
            OP_SUB:  result_value = rs1_q[head_q] - rs2_q[head_q];
            default: result_value = '0;
        endcase
    end
`endif

    // Result fields are captured once on entering RESULT so they stay
    // stable while the core stalls, and return to zero after the pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_we_q   <= 1'b0;
        end else if (load_result) begin
            res_id_q   <= head_e.id[IdW-1:0];
            res_data_q <= result_value;
            res_rd_q   <= head_e.rd;
            res_we_q   <= head_e.writeback;
        end else if ((state_q == S_RESULT) && pop) begin
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_we_q   <= 1'b0;
        end
    end

    assign x_if.issue_ready_o     = !full;
    assign x_if.issue_accept_o    = dec_accept;
    assign x_if.issue_writeback_o = dec_writeback;
    assign x_if.issue_regread_o   = dec_regread;
    assign x_if.register_ready_o  = reg_hit;
    assign x_if.result_valid_o    = (state_q == S_RESULT);
    assign x_if.result_id_o       = res_id_q;
    assign x_if.result_data_o     = res_data_q;
    assign x_if.result_rd_o       = res_rd_q;
    assign x_if.result_we_o       = res_we_q;

`ifndef SYNTHESIS
    register_id_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
        reg_fire |-> (reg_target_id == ID_MAX_W'(x_if.register_id_i)));
`endif

endmodule
